// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit ALU: default width, opcode type and
// opcode encodings formed as {sel1, sel0}.
package alu16_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_ADD = 2'b00;
    localparam opcode_t OP_SUB = 2'b01;
    localparam opcode_t OP_AND = 2'b10;
    localparam opcode_t OP_OR  = 2'b11;

endpackage

// File: rtl/alu16_addsub.sv
// Combinational adder/subtractor: subtraction runs as a + ~b + 1 and the
// carry output is reported as a borrow in that mode.
module alu16_addsub
    import alu16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];

    // Borrow is the inverted carry-out of the a + ~b + 1 form.
    assign carry = sub ? ~full[WIDTH] : full[WIDTH];

    // Same-sign operands (after b inversion) producing a differently-signed
    // result; the carry-in cannot cause overflow for mixed-sign operands.
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu16bit.sv
// Four-function ALU (add, sub, and, or) with a registered result and
// carry/zero/negative/overflow flags, one cycle of latency.
module alu16bit
    import alu16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel0,
    input  logic             sel1,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    opcode_t          op;
    logic             sub_sel;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] res_p0;
    logic             carry_p0;
    logic             ovf_p0;
    logic             zero_p0;
    logic             neg_p0;

    assign op      = {sel1, sel0};
    assign sub_sel = (op == OP_SUB);

    alu16_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a       (a),
        .b       (b),
        .sub     (sub_sel),
        .sum     (as_sum),
        .carry   (as_carry),
        .overflow(as_ovf)
    );

    always_comb begin
        res_p0   = '0;
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_p0   = as_sum;
                carry_p0 = as_carry;
                ovf_p0   = as_ovf;
            end
            OP_AND:  res_p0 = a & b;
            default: res_p0 = a | b;
        endcase
    end

    assign zero_p0 = (res_p0 == '0);
    assign neg_p0  = res_p0[WIDTH-1];

    // Stage boundary: decoded result and flags into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            out      <= res_p0;
            carry    <= carry_p0;
            zero     <= zero_p0;
            negative <= neg_p0;
            overflow <= ovf_p0;
        end
    end

endmodule

// File: tb/tb_alu16bit.sv
// Directed and random checks of alu16bit: reset, each operation, wrap and
// overflow corners, asynchronous reset mid-stream, and a reference model.
module tb_alu16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        sel0;
    logic        sel1;
    logic [15:0] out;
    logic        carry;
    logic        zero;
    logic        negative;
    logic        overflow;

    int n_checks;
    int n_fail;

    alu16bit #(
        .WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .sel0    (sel0),
        .sel1    (sel1),
        .out     (out),
        .carry   (carry),
        .zero    (zero),
        .negative(negative),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_out, input logic e_c,
                             input logic e_z, input logic e_n, input logic e_v);
        check({tag, ".out"}, {16'h0, out}, {16'h0, e_out});
        check({tag, ".carry"}, {31'h0, carry}, {31'h0, e_c});
        check({tag, ".zero"}, {31'h0, zero}, {31'h0, e_z});
        check({tag, ".negative"}, {31'h0, negative}, {31'h0, e_n});
        check({tag, ".overflow"}, {31'h0, overflow}, {31'h0, e_v});
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic [1:0] vs, input logic [15:0] e_out, input logic e_c,
                           input logic e_z, input logic e_n, input logic e_v);
        @(negedge clk);
        a = va;
        b = vb;
        {sel1, sel0} = vs;
        @(posedge clk);
        #1;
        check_all(tag, e_out, e_c, e_z, e_n, e_v);
    endtask

    // Reference: carry/borrow from widened unsigned math, overflow from
    // signed integer range.
    function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic [1:0] ms);
        logic [16:0] wide;
        logic [15:0] r;
        logic        c;
        logic        v;
        int          sa;
        int          sb;
        int          sr;
        sa = $signed(ma);
        sb = $signed(mb);
        c  = 1'b0;
        v  = 1'b0;
        case (ms)
            2'b00: begin
                wide = {1'b0, ma} + {1'b0, mb};
                r    = wide[15:0];
                c    = wide[16];
                sr   = sa + sb;
                v    = (sr > 32767) || (sr < -32768);
            end
            2'b01: begin
                r  = ma - mb;
                c  = (ma < mb);
                sr = sa - sb;
                v  = (sr > 32767) || (sr < -32768);
            end
            2'b10:   r = ma & mb;
            default: r = ma | mb;
        endcase
        return {c, (r == 16'h0), r[15], v, r};
    endfunction

    logic [15:0] corners [5];
    logic [19:0] exp_v;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rs;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        corners[0] = 16'h0000;
        corners[1] = 16'h0001;
        corners[2] = 16'h7FFF;
        corners[3] = 16'h8000;
        corners[4] = 16'hFFFF;

        rst_n = 1'b1;
        a     = 16'h1234;
        b     = 16'h4321;
        sel0  = 1'b0;
        sel1  = 1'b0;
        #1;
        rst_n = 1'b0;

        // Held in reset with changing inputs across several edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a    = 16'($urandom);
            b    = 16'($urandom);
            sel0 = 1'($urandom);
            sel1 = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("reset_hold", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Release on a falling edge; first result follows the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'd1;
        b = 16'd2;
        {sel1, sel0} = 2'b00;
        #1;
        check("release_pre_edge.out", {16'h0, out}, 32'h0);
        @(posedge clk);
        #1;
        check_all("release_first", 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        run_vec("add_20_38", 16'd20, 16'd38, 2'b00, 16'd58, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("sub_8_5",   16'd8,  16'd5,  2'b01, 16'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("and_5_4",   16'd5,  16'd4,  2'b10, 16'd4,  1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("or_6_3",    16'd6,  16'd3,  2'b11, 16'd7,  1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("add_wrap",  16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_vec("sub_5_8",   16'd5,  16'd8,  2'b01, 16'hFFFD, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("add_ovf",   16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_vec("sub_ovf",   16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("sub_0_1",   16'h0000, 16'h0001, 2'b01, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_vec("and_zero",  16'hF0F0, 16'h0F0F, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("or_neg",    16'h8000, 16'h0001, 2'b11, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);

        // Async reset pulse between edges while streaming adds.
        run_vec("stream_0", 16'd100, 16'd200, 2'b00, 16'd300, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("stream_1", 16'd101, 16'd200, 2'b00, 16'd301, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_clear", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("async_held", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'd7;
        b = 16'd9;
        {sel1, sel0} = 2'b00;
        @(posedge clk);
        #1;
        check_all("resume_0", 16'd16, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("resume_1", 16'h8000, 16'h8000, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Random stream against the reference model, with corner operands mixed in.
        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : 16'($urandom);
            rb = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : 16'($urandom);
            rs = 2'($urandom);
            exp_v = model(ra, rb, rs);
            run_vec("rand", ra, rb, rs, exp_v[15:0], exp_v[19], exp_v[18], exp_v[17], exp_v[16]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
